rtc_mux_bus_seq: RTL and testbench

- Parametrised successor to the fixed V3023-style access path.
- Runs burst write or read transactions of 1..NREG consecutive registers over a multiplexed address/data bus, using active-low CS/AD/WR/RD strobes.
- Strobe phase timing is programmable.
- Sits between the clock/timer control FSMs and the inout bus pins; the top level ties bus_out/bus_oe/bus_in to the inout bus.

---
 rtl/rtc_mux_bus_seq_if.sv | 38 +++
 rtl/rtc_mux_bus_seq.sv | 203 ++++++++++++++++++++
 tb/tb_rtc_mux_bus_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rtc_mux_bus_seq_if.sv
// Bus bundle for rtc_mux_bus_seq: request/handshake signals to the
// control FSMs plus the multiplexed RTC bus strobes and data lines.
interface rtc_mux_bus_seq_if #(
  parameter int DW = 8,
  parameter int LW = 4
);
  logic          start;
  logic          rw;
  logic [DW-1:0] base_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] wr_data;
  logic          wd_take;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [LW-1:0] rd_idx;
  logic          busy;
  logic          done;
  logic          err;
  logic          CS_n;
  logic          AD_n;
  logic          WR_n;
  logic          RD_n;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic [DW-1:0] bus_in;

  modport master (
    output start, rw, base_addr, len, wr_data, bus_in,
    input  wd_take, rd_data, rd_valid, rd_idx, busy, done, err,
    input  CS_n, AD_n, WR_n, RD_n, bus_out, bus_oe
  );

  modport slave (
    input  start, rw, base_addr, len, wr_data, bus_in,
    output wd_take, rd_data, rd_valid, rd_idx, busy, done, err,
    output CS_n, AD_n, WR_n, RD_n, bus_out, bus_oe
  );
endinterface

// File: rtl/rtc_mux_bus_seq.sv
// Burst read/write sequencer for a multiplexed-address/data RTC bus.
// Ports: CLK, Reset (async, active high), bus (rtc_mux_bus_seq_if.slave).
// Optional macro RTC_WRVERIFY_EN: read back each written word, set err.
module rtc_mux_bus_seq #(
  parameter int DW   = 8,
  parameter int NREG = 9,
  parameter int LW   = 4,
  parameter int T_PH = 4
) (
  input logic             CLK,
  input logic             Reset,
  rtc_mux_bus_seq_if.slave bus
);

  localparam int PW = (T_PH > 1) ? $clog2(T_PH) : 1;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] A_SET  = 4'd1;
  localparam logic [3:0] A_STB  = 4'd2;
  localparam logic [3:0] A_HLD  = 4'd3;
  localparam logic [3:0] D_SET  = 4'd4;
  localparam logic [3:0] D_STB  = 4'd5;
  localparam logic [3:0] D_HLD  = 4'd6;
  localparam logic [3:0] CS_REL = 4'd7;
  localparam logic [3:0] FIN    = 4'd8;

  logic [3:0]    r_st;
  logic [PW-1:0] r_ph;
  logic          r_rw;
  logic [DW-1:0] r_addr;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_idx;
  logic [DW-1:0] r_wdat;
  logic [DW-1:0] r_rdat;
  logic          r_rdv;
  logic [LW-1:0] r_rdix;

  logic          w_last;
  logic          w_rd;
  logic          w_vfy;
  logic [LW-1:0] w_len;
  logic [LW-1:0] w_nidx;

  logic          w_cs, w_ad, w_wr, w_rdn, w_oe, w_take;
  logic [DW-1:0] w_out;

`ifdef RTC_WRVERIFY_EN
  logic r_vfy;
  logic r_err;
  assign w_vfy   = r_vfy;
  assign bus.err = r_err;
`else
  assign w_vfy   = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign w_last = (r_ph == PW'(T_PH - 1));
  // verify passes behave exactly like reads on the bus
  assign w_rd   = !r_rw || w_vfy;
  assign w_len  = (bus.len > LW'(NREG)) ? LW'(NREG) : bus.len;
  assign w_nidx = r_idx + LW'(1);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_st   <= IDLE;
      r_ph   <= '0;
      r_rw   <= 1'b0;
      r_addr <= '0;
      r_cnt  <= '0;
      r_idx  <= '0;
      r_wdat <= '0;
      r_rdat <= '0;
      r_rdv  <= 1'b0;
      r_rdix <= '0;
`ifdef RTC_WRVERIFY_EN
      r_vfy  <= 1'b0;
      r_err  <= 1'b0;
`endif
    end else begin
      r_rdv <= 1'b0;
      unique case (r_st)
        IDLE: begin
          r_ph <= '0;
          if (bus.start) begin
            r_rw   <= bus.rw;
            r_addr <= bus.base_addr;
            r_cnt  <= w_len;
            r_idx  <= '0;
            r_st   <= (w_len == '0) ? FIN : A_SET;
`ifdef RTC_WRVERIFY_EN
            r_vfy  <= 1'b0;
            r_err  <= 1'b0;
`endif
          end
        end
        FIN: r_st <= IDLE;
        default: begin
          r_ph <= w_last ? '0 : r_ph + PW'(1);
          if (r_st == D_SET && r_ph == '0 && !w_rd)
            r_wdat <= bus.wr_data;
          if (r_st == D_STB && w_last && w_rd) begin
`ifdef RTC_WRVERIFY_EN
            if (r_vfy) begin
              if (bus.bus_in != r_wdat)
                r_err <= 1'b1;
            end else begin
              r_rdat <= bus.bus_in;
              r_rdv  <= 1'b1;
              r_rdix <= r_idx;
            end
`else
            r_rdat <= bus.bus_in;
            r_rdv  <= 1'b1;
            r_rdix <= r_idx;
`endif
          end
          if (w_last) begin
            unique case (r_st)
              A_SET:  r_st <= A_STB;
              A_STB:  r_st <= A_HLD;
              A_HLD:  r_st <= D_SET;
              D_SET:  r_st <= D_STB;
              D_STB:  r_st <= D_HLD;
              D_HLD: begin
`ifdef RTC_WRVERIFY_EN
                if (r_rw && !r_vfy) begin
                  r_vfy <= 1'b1;
                  r_st  <= A_SET;
                end else begin
                  r_vfy  <= 1'b0;
                  r_idx  <= w_nidx;
                  r_addr <= r_addr + DW'(1);
                  r_st   <= (w_nidx == r_cnt) ? CS_REL : A_SET;
                end
`else
                r_idx  <= w_nidx;
                r_addr <= r_addr + DW'(1);
                r_st   <= (w_nidx == r_cnt) ? CS_REL : A_SET;
`endif
              end
              CS_REL: r_st <= FIN;
              default: r_st <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    w_cs   = 1'b1;
    w_ad   = 1'b1;
    w_wr   = 1'b1;
    w_rdn  = 1'b1;
    w_oe   = 1'b0;
    w_out  = '0;
    w_take = 1'b0;
    unique case (r_st)
      A_SET, A_STB, A_HLD: begin
        w_cs  = 1'b0;
        w_ad  = 1'b0;
        w_oe  = 1'b1;
        w_out = r_addr;
        w_wr  = (r_st != A_STB);
      end
      D_SET: begin
        w_cs = 1'b0;
        if (!w_rd) begin
          w_oe   = 1'b1;
          w_take = (r_ph == '0);
          // first cycle forwards wr_data while it is being captured
          w_out  = w_take ? bus.wr_data : r_wdat;
        end
      end
      D_STB: begin
        w_cs = 1'b0;
        if (!w_rd) begin
          w_wr  = 1'b0;
          w_oe  = 1'b1;
          w_out = r_wdat;
        end else begin
          w_rdn = 1'b0;
        end
      end
      D_HLD: w_cs = 1'b0;
      default: ;
    endcase
  end

  assign bus.CS_n     = w_cs;
  assign bus.AD_n     = w_ad;
  assign bus.WR_n     = w_wr;
  assign bus.RD_n     = w_rdn;
  assign bus.bus_oe   = w_oe;
  assign bus.bus_out  = w_out;
  assign bus.wd_take  = w_take;
  assign bus.rd_data  = r_rdat;
  assign bus.rd_valid = r_rdv;
  assign bus.rd_idx   = r_rdix;
  assign bus.done     = (r_st == FIN);
  assign bus.busy     = (r_st != IDLE) && (r_st != FIN);

endmodule

// File: tb/tb_rtc_mux_bus_seq.sv
// Directed bench for rtc_mux_bus_seq with T_PH=2 and a bus model
// that answers each read with (latched address + 1).
module tb_rtc_mux_bus_seq;

`ifdef RTC_WRVERIFY_EN
  localparam int VF = 2;
`else
  localparam int VF = 1;
`endif

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic [7:0] r_lat = 8'h00;

  int n_run = 0;
  int n_fail = 0;

  int nwd, naw, viol, anylow, nrd;
  logic [7:0] q_addr[$];
  logic [7:0] q_wdat[$];
  logic [7:0] q_rd[$];
  logic [3:0] q_ix[$];
  logic err_done, busy_done;

  rtc_mux_bus_seq_if #(.DW(8), .LW(4)) bif ();

  rtc_mux_bus_seq #(.DW(8), .NREG(9), .LW(4), .T_PH(2)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bif.slave)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (!bif.AD_n && bif.bus_oe)
      r_lat <= bif.bus_out;

  assign bif.bus_in = r_lat + 8'h01;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic w, input logic [7:0] a,
                     input logic [3:0] l, input logic [7:0] d,
                     output int dcyc);
    logic pw;
    q_addr.delete();
    q_wdat.delete();
    q_rd.delete();
    q_ix.delete();
    nwd = 0; naw = 0; viol = 0; anylow = 0; nrd = 0;
    dcyc = -1;
    pw = 1'b1;
    @(negedge CLK);
    bif.start = 1'b1;
    bif.rw = w;
    bif.base_addr = a;
    bif.len = l;
    bif.wr_data = d;
    for (int k = 1; k <= 400; k++) begin
      @(negedge CLK);
      if (k == 1) bif.start = 1'b0;
      if (bif.wd_take) nwd++;
      if (!bif.AD_n && !bif.WR_n) naw++;
      if (!bif.AD_n && !bif.WR_n && pw) q_addr.push_back(bif.bus_out);
      if (bif.AD_n && !bif.CS_n && !bif.WR_n && pw)
        q_wdat.push_back(bif.bus_out);
      if (!bif.WR_n && !bif.RD_n) viol++;
      if (!bif.RD_n && bif.bus_oe) viol++;
      if (!bif.CS_n || !bif.AD_n || !bif.WR_n || !bif.RD_n) anylow++;
      if (bif.rd_valid) begin
        nrd++;
        q_rd.push_back(bif.rd_data);
        q_ix.push_back(bif.rd_idx);
      end
      pw = bif.WR_n;
      if (bif.done) begin
        dcyc = k;
        err_done = bif.err;
        busy_done = bif.busy;
        break;
      end
    end
  endtask

  int dc;

  initial begin
    bif.start = 1'b0;
    bif.rw = 1'b0;
    bif.base_addr = 8'h00;
    bif.len = 4'd0;
    bif.wr_data = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_cs", bif.CS_n, 1);
    chk("rst_oe", bif.bus_oe, 0);
    chk("rst_out", bif.bus_out, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_rdv", bif.rd_valid, 0);
    chk("rst_err", bif.err, 0);
    Reset = 1'b0;

    // single write
    run(1'b1, 8'h21, 4'd1, 8'h45, dc);
    chk("wr_done", dc, 1 + 12 * VF + 2);
    chk("wr_take", nwd, 1);
    chk("wr_addr", q_addr.size() > 0 ? q_addr[0] : 8'hxx, 8'h21);
    chk("wr_awr", naw, 2 * VF);
    chk("wr_data", q_wdat.size() > 0 ? q_wdat[0] : 8'hxx, 8'h45);
    chk("wr_busy", busy_done, 0);

    // three word read
    run(1'b0, 8'h22, 4'd3, 8'h00, dc);
    chk("rd_done", dc, 39);
    chk("rd_n", nrd, 3);
    for (int i = 0; i < 3; i++) begin
      chk("rd_data", i < q_rd.size() ? q_rd[i] : 8'hxx, 8'h23 + i);
      chk("rd_idx", i < q_ix.size() ? q_ix[i] : 4'hx, i);
    end
    chk("rd_inv", viol, 0);

    // address wrap
    run(1'b0, 8'hFF, 4'd2, 8'h00, dc);
    chk("wrap_a0", q_addr.size() > 0 ? q_addr[0] : 8'hxx, 8'hFF);
    chk("wrap_a1", q_addr.size() > 1 ? q_addr[1] : 8'hxx, 8'h00);
    chk("wrap_d1", q_rd.size() > 1 ? q_rd[1] : 8'hxx, 8'h01);

    // zero length
    run(1'b0, 8'h10, 4'd0, 8'h00, dc);
    chk("len0_done", dc, 1);
    chk("len0_low", anylow, 0);

    // clamped length
    run(1'b0, 8'h50, 4'd15, 8'h00, dc);
    chk("clamp_n", nrd, 9);
    chk("clamp_done", dc, 1 + 12 * 9 + 2);
    chk("clamp_last", q_ix.size() > 8 ? q_ix[8] : 4'hx, 8);

    // reset during D_STB of second word
    @(negedge CLK);
    bif.start = 1'b1;
    bif.rw = 1'b0;
    bif.base_addr = 8'h30;
    bif.len = 4'd3;
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLK);
      if (k == 1) bif.start = 1'b0;
    end
    chk("mid_rd", bif.RD_n, 0);
    Reset = 1'b1;
    #1;
    chk("mid_cs", bif.CS_n, 1);
    chk("mid_rdn", bif.RD_n, 1);
    chk("mid_oe", bif.bus_oe, 0);
    chk("mid_busy", bif.busy, 0);
    anylow = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (bif.done) anylow++;
    end
    chk("mid_nodone", anylow, 0);
    Reset = 1'b0;
    run(1'b0, 8'h40, 4'd1, 8'h00, dc);
    chk("post_done", dc, 15);
    chk("post_data", q_rd.size() > 0 ? q_rd[0] : 8'hxx, 8'h41);

`ifdef RTC_WRVERIFY_EN
    run(1'b1, 8'h21, 4'd1, 8'h12, dc);
    chk("vfy_err", err_done, 1);
    chk("vfy_nrd", nrd, 0);
    @(negedge CLK);
    chk("vfy_sticky", bif.err, 1);
    run(1'b0, 8'h10, 4'd0, 8'h00, dc);
    chk("vfy_clr", err_done, 0);
`else
    chk("noverify_err", bif.err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
